// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM encoding,
// fixed field widths and the saturating counter helper used by DCACHE_STAT_EN.
package dcache_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int WORD_W    = 32;
    localparam int BYTE_BITS = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_ctrl_line_array.sv
// Tag/valid/dirty/data storage for dcache_ctrl: one asynchronous read port
// (whole-line metadata plus one selected word) and one synchronous write port.
module cache_line_array
    import dcache_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64,
    parameter int TAG_BITS   = 22,
    parameter int IDX_BITS   = $clog2(LINES),
    parameter int WORD_BITS  = $clog2(LINE_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_BITS-1:0]  rd_idx,
    input  logic [WORD_BITS-1:0] rd_word,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [WORD_W-1:0]    rd_data,
    input  logic                 wr_data_en,
    input  logic                 wr_meta_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [WORD_BITS-1:0] wr_word,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic                 wr_valid,
    input  logic                 wr_dirty
);

    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [WORD_W-1:0]   data_mem [LINES*LINE_WORDS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_meta_en) begin
            valid_d[wr_idx] = wr_valid;
            dirty_d[wr_idx] = wr_dirty;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data are plain storage: no reset, so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_meta_en) tag_mem[wr_idx] <= wr_tag;
        if (wr_data_en) data_mem[{wr_idx, wr_word}] <= wr_data;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[{rd_idx, rd_word}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate MEM-stage data cache with word-serial
// refill and write-back. Optional hit/miss counters under `DCACHE_STAT_EN.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64,
    parameter int ADDR_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic                 cpu_ren,
    input  logic                 cpu_wen,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_ren,
    output logic                 ram_wen,
    output logic [31:0]          ram_dout,
    input  logic [31:0]          ram_din,
    input  logic                 ram_ack
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
`endif
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int TAG_BITS  = ADDR_BITS - IDX_BITS - WORD_BITS - BYTE_BITS;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

    state_e               state_q, state_d;
    logic [WORD_BITS-1:0] cnt_q, cnt_d;
    logic [IDX_BITS-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_BITS-1:0]  miss_tag_q, miss_tag_d;

    logic [WORD_BITS-1:0] cpu_word;
    logic [IDX_BITS-1:0]  cpu_idx;
    logic [TAG_BITS-1:0]  cpu_tag;
    logic                 req, store, hit;
    logic                 unused_byte_bits;

    logic [IDX_BITS-1:0]  rd_idx;
    logic [WORD_BITS-1:0] rd_word;
    logic                 rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [31:0]          rd_data;
    logic                 wr_data_en, wr_meta_en, wr_valid, wr_dirty;
    logic [IDX_BITS-1:0]  wr_idx;
    logic [WORD_BITS-1:0] wr_word;
    logic [31:0]          wr_data;
    logic [TAG_BITS-1:0]  wr_tag;

    assign cpu_word         = cpu_addr[BYTE_BITS +: WORD_BITS];
    assign cpu_idx          = cpu_addr[BYTE_BITS+WORD_BITS +: IDX_BITS];
    assign cpu_tag          = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    assign unused_byte_bits = ^cpu_addr[BYTE_BITS-1:0];
    assign req              = cpu_ren | cpu_wen;
    assign store            = cpu_wen;

    // During a transfer the line is addressed from the latched miss, so a
    // request dropped mid-miss cannot redirect the burst.
    assign rd_idx  = (state_q == ST_WB || state_q == ST_FILL) ? miss_idx_q : cpu_idx;
    assign rd_word = (state_q == ST_WB) ? cnt_q : cpu_word;
    assign hit     = rd_valid && (rd_tag == cpu_tag);

    cache_line_array #(
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (rd_idx),
        .rd_word    (rd_word),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_data_en (wr_data_en),
        .wr_meta_en (wr_meta_en),
        .wr_idx     (wr_idx),
        .wr_word    (wr_word),
        .wr_data    (wr_data),
        .wr_tag     (wr_tag),
        .wr_valid   (wr_valid),
        .wr_dirty   (wr_dirty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        cpu_stall  = 1'b0;
        cpu_dout   = '0;
        ram_addr   = '0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_dout   = '0;
        wr_data_en = 1'b0;
        wr_meta_en = 1'b0;
        wr_idx     = miss_idx_q;
        wr_word    = cnt_q;
        wr_data    = ram_din;
        wr_tag     = miss_tag_q;
        wr_valid   = 1'b1;
        wr_dirty   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req && hit) begin
                    if (store) begin
                        wr_data_en = 1'b1;
                        wr_meta_en = 1'b1;
                        wr_idx     = cpu_idx;
                        wr_word    = cpu_word;
                        wr_data    = cpu_din;
                        wr_tag     = cpu_tag;
                        wr_dirty   = 1'b1;
                    end else begin
                        cpu_dout = rd_data;
                    end
                end else if (req) begin
                    cpu_stall  = 1'b1;
                    miss_idx_d = cpu_idx;
                    miss_tag_d = cpu_tag;
                    cnt_d      = '0;
                    state_d    = (rd_valid && rd_dirty) ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                cpu_stall = 1'b1;
                ram_wen   = 1'b1;
                ram_addr  = {rd_tag, miss_idx_q, cnt_q, 2'b00};
                ram_dout  = rd_data;
                if (ram_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        wr_meta_en = 1'b1;
                        wr_tag     = rd_tag;
                        cnt_d      = '0;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                cpu_stall = 1'b1;
                ram_ren   = 1'b1;
                ram_addr  = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
                if (ram_ack) begin
                    wr_data_en = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        wr_meta_en = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cpu_stall = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset must silence the outputs immediately, not at the next edge.
        if (!rst) begin
            cpu_stall  = 1'b0;
            cpu_dout   = '0;
            ram_addr   = '0;
            ram_ren    = 1'b0;
            ram_wen    = 1'b0;
            ram_dout   = '0;
            wr_data_en = 1'b0;
            wr_meta_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
        end
    end

`ifdef DCACHE_STAT_EN
    logic [31:0] hits_q, hits_d, misses_q, misses_d;
    logic        after_done_q, after_done_d;

    // The IDLE cycle right after DONE completes an already-counted miss.
    always_comb begin
        hits_d       = hits_q;
        misses_d     = misses_q;
        after_done_d = (state_q == ST_DONE);
        if (state_q == ST_IDLE && req) begin
            if (!hit)               misses_d = sat_inc(misses_q);
            else if (!after_done_q) hits_d   = sat_inc(hits_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q       <= '0;
            misses_q     <= '0;
            after_done_q <= 1'b0;
        end else begin
            hits_q       <= hits_d;
            misses_q     <= misses_d;
            after_done_q <= after_done_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed miss/hit/eviction/reset cases
// followed by randomized traffic against an array-based cache and memory model.
module tb_dcache_ctrl;

    localparam int LW = 4;
    localparam int NL = 64;
    localparam int AB = 32;
    localparam int TB = AB - 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ren = 1'b0, cpu_wen = 1'b0;
    logic [31:0] cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic [31:0] ram_addr;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_dout;
    logic [31:0] ram_din = '0;
    logic        ram_ack = 1'b0;
`ifdef DCACHE_STAT_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.LINE_WORDS(LW), .LINES(NL), .ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_ren   (cpu_ren),
        .cpu_wen   (cpu_wen),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_stall (cpu_stall),
        .ram_addr  (ram_addr),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .ram_ack   (ram_ack)
`ifdef DCACHE_STAT_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: cache contents per line and a sparse backing memory.
    bit          m_valid [NL];
    bit          m_dirty [NL];
    logic [TB-1:0] m_tag [NL];
    logic [31:0] m_data  [NL][LW];
    logic [31:0] mem [logic [31:0]];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0000);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic beat(input string tag, input bit wb, input logic [31:0] ba,
                        input logic [31:0] d, input int dly);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            ram_ack = (c == dly);
            ram_din = wb ? 32'hBAD0_BAD0 : d;
            #1;
            chk({tag, "_stall"}, cpu_stall, 1);
            chk({tag, "_en"}, {ram_ren, ram_wen}, wb ? 2'b01 : 2'b10);
            chk({tag, "_addr"}, ram_addr, ba);
            if (wb) chk({tag, "_dout"}, ram_dout, d);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        ram_ack = 1'b0;
        #1;
        chk("idle_stall", cpu_stall, 0);
        chk("idle_ram", {ram_ren, ram_wen}, 0);
    endtask

    // One CPU request, held until it completes. rst_beat >= 0 aborts the
    // refill by reset during that fill beat.
    task automatic do_req(input logic [31:0] addr, input bit store, input bit both,
                          input logic [31:0] wdata, input int dly, input int rst_beat);
        int            idx;
        int            w;
        logic [TB-1:0] tg;
        logic [31:0]   ba;
        logic [31:0]   d;
        idx = int'((addr >> 4) % NL);
        w   = int'((addr >> 2) % LW);
        tg  = addr[31:10];
        @(negedge clk);
        cpu_addr = addr;
        cpu_ren  = !store || both;
        cpu_wen  = store;
        cpu_din  = wdata;
        ram_ack  = 1'b0;
        #1;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            m_hits++;
            chk("hit_stall", cpu_stall, 0);
            chk("hit_ram", {ram_ren, ram_wen}, 0);
            if (store) begin
                m_data[idx][w] = wdata;
                m_dirty[idx]   = 1'b1;
            end else begin
                chk("hit_dout", cpu_dout, m_data[idx][w]);
            end
            return;
        end
        m_misses++;
        chk("miss_stall", cpu_stall, 1);
        if (m_valid[idx] && m_dirty[idx]) begin
            for (int k = 0; k < LW; k++) begin
                ba = (32'(m_tag[idx]) << 10) | (32'(idx) << 4) | (32'(k) << 2);
                beat("wb", 1'b1, ba, m_data[idx][k], dly);
                mem[ba] = m_data[idx][k];
            end
            m_dirty[idx] = 1'b0;
        end
        for (int k = 0; k < LW; k++) begin
            ba = (addr & ~32'hF) + 32'(k * 4);
            d  = mem_rd(ba);
            if (k == rst_beat) begin
                @(negedge clk);
                ram_ack = 1'b0;
                #1;
                chk("pre_rst_ren", ram_ren, 1);
                rst = 1'b0;
                #1;
                chk("rst_ren", ram_ren, 0);
                chk("rst_stall", cpu_stall, 0);
                chk("rst_addr", ram_addr, 0);
                model_reset();
                cpu_ren = 1'b0;
                cpu_wen = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            beat("fill", 1'b0, ba, d, dly);
            m_data[idx][k] = d;
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_dirty[idx] = 1'b0;
        @(negedge clk);
        ram_ack = 1'b0;
        #1;
        chk("done_stall", cpu_stall, 1);
        chk("done_ram", {ram_ren, ram_wen}, 0);
        @(negedge clk);
        #1;
        chk("fin_stall", cpu_stall, 0);
        if (store) begin
            m_data[idx][w] = wdata;
            m_dirty[idx]   = 1'b1;
        end else begin
            chk("fin_dout", cpu_dout, m_data[idx][w]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          st;
        model_reset();
        mem[32'h40] = 32'h11;
        mem[32'h44] = 32'h22;
        mem[32'h48] = 32'h33;
        mem[32'h4C] = 32'h44;

        // Reset state, with a request and a stray ack presented.
        cpu_addr = 32'h40;
        cpu_ren  = 1'b1;
        ram_ack  = 1'b1;
        #3;
        chk("rst_stall0", cpu_stall, 0);
        chk("rst_en0", {ram_ren, ram_wen}, 0);
        chk("rst_addr0", ram_addr, 0);
        chk("rst_rdout0", ram_dout, 0);
        chk("rst_cdout0", cpu_dout, 0);
        @(negedge clk);
        cpu_ren = 1'b0;
        ram_ack = 1'b0;
        rst     = 1'b1;
        idle_cycle();

        do_req(32'h40, 1'b0, 1'b0, 0, 0, -1);
        do_req(32'h48, 1'b0, 1'b0, 0, 0, -1);
        chk("t2_dout", cpu_dout, 32'h33);
        do_req(32'h44, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, -1);
        do_req(32'h1040, 1'b0, 1'b0, 0, 0, -1);
        chk("t3_wb_mem", mem_rd(32'h44), 32'hDEAD_BEEF);
`ifdef DCACHE_STAT_EN
        chk("stat_hits_t3", stat_hits, 32'd2);
        chk("stat_misses_t3", stat_misses, 32'd2);
`endif
        idle_cycle();

        // Slow memory: three-cycle ack delay on a dirty eviction.
        do_req(32'h1044, 1'b1, 1'b0, 32'hCAFE_0001, 0, -1);
        do_req(32'h2048, 1'b0, 1'b0, 0, 3, -1);

        // Reset in the middle of a refill, then a clean full refill.
        do_req(32'h40, 1'b0, 1'b0, 0, 0, 1);
        idle_cycle();
        do_req(32'h40, 1'b0, 1'b0, 0, 0, -1);
        do_req(32'h44, 1'b0, 1'b0, 0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(4, 6)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            st = ($urandom_range(0, 9) < 4);
            do_req(a, st, ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 2), -1);
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end
        idle_cycle();
`ifdef DCACHE_STAT_EN
        chk("stat_hits_end", stat_hits, 32'(m_hits));
        chk("stat_misses_end", stat_misses, 32'(m_misses));
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
